// File: rtl/rfphoenix_icache_refill.sv
// Icache lookup and refill engine: compares the four way tags for a fetch
// index, and on a miss fetches the 64-byte line over the bus, then installs it
// in the tag/data RAMs and retries the lookup so the fetch completes as a hit.
module rfphoenix_icache_refill #(
  parameter int AWID  = 32,
  parameter int LINES = 128,
  parameter int WAYS  = 4,
  parameter int BEATS = 4,
  parameter int TMO   = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req,
  input  logic [AWID-1:0]       ip,
  output logic [6:0]            ndx,
  input  logic [4*(AWID-6)-1:0] tags_i,
  output logic                  hit,
  output logic [1:0]            hit_way,
  output logic                  busy,
  output logic                  mem_req,
  output logic [AWID-1:0]       mem_adr,
  input  logic                  mem_ack,
  input  logic [127:0]          mem_dat,
  input  logic                  mem_err,
  output logic [511:0]          line_o,
  output logic                  line_wr,
  output logic                  tag_wr,
  output logic [AWID-1:0]       tag_ipo,
  output logic [1:0]            tag_way,
  output logic                  err
);

  localparam int TAGW = AWID - 6;
  localparam int BW   = $clog2(BEATS);
  localparam int TW   = $clog2(TMO + 1);

  typedef enum logic [1:0] {IDLE, CHECK, FETCH, WRITE} state_t;

  state_t                     state;
  logic [TAGW-1:0]            tag_r;
  logic [6:0]                 set_r;
  logic [WAYS-1:0][LINES-1:0] vld;
  logic [1:0]                 victim;
  logic [BW-1:0]              beat;
  logic [TW-1:0]              tmo;
  logic [WAYS-1:0]            way_hit;
  logic [1:0]                 first_way;
  logic                       any_hit;
  logic                       tmo_expired;
  logic                       unused_ip;

  // Offset bits within the line never affect lookup or refill.
  assign unused_ip = ^ip[5:0];

  // Only the line address of the fetch is kept; the set index is its low 7 bits.
  assign set_r = tag_r[6:0];

  // The tag RAM is read from the live fetch address while idle so its data is
  // ready in CHECK; afterwards the captured address keeps the index stable.
  assign ndx = (state == IDLE) ? ip[12:6] : set_r;

  // Per-way hit detection against the captured line address.
  always_comb begin
    way_hit = '0;
    for (int w = 0; w < WAYS; w++)
      way_hit[w] = vld[w][set_r] && (tags_i[w*TAGW +: TAGW] == tag_r);
  end

  // Priority select: the lowest hitting way wins if several match.
  always_comb begin
    first_way = 2'd0;
    for (int w = WAYS - 1; w >= 0; w--)
      if (way_hit[w]) first_way = 2'(w);
  end

  assign any_hit     = |way_hit;
  assign tmo_expired = !mem_ack && (tmo == TW'(TMO - 1));

  // Main lookup/refill state machine with all outputs registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      tag_r   <= '0;
      vld     <= '0;
      victim  <= 2'd0;
      beat    <= '0;
      tmo     <= '0;
      hit     <= 1'b0;
      hit_way <= 2'd0;
      busy    <= 1'b0;
      mem_req <= 1'b0;
      mem_adr <= '0;
      line_o  <= '0;
      line_wr <= 1'b0;
      tag_wr  <= 1'b0;
      tag_ipo <= '0;
      tag_way <= 2'd0;
      err     <= 1'b0;
    end else begin
      hit     <= 1'b0;
      err     <= 1'b0;
      tag_wr  <= 1'b0;
      line_wr <= 1'b0;
      case (state)
        IDLE: begin
          if (req) begin
            tag_r <= ip[AWID-1:6];
            busy  <= 1'b1;
            state <= CHECK;
          end
        end
        CHECK: begin
          if (any_hit) begin
            hit     <= 1'b1;
            hit_way <= first_way;
            busy    <= 1'b0;
            state   <= IDLE;
          end else begin
            tag_way <= victim;
            beat    <= '0;
            tmo     <= '0;
            mem_adr <= {tag_r, 6'd0};
            mem_req <= 1'b1;
            state   <= FETCH;
          end
        end
        FETCH: begin
          if (mem_err || tmo_expired) begin
            mem_req <= 1'b0;
            err     <= 1'b1;
            busy    <= 1'b0;
            state   <= IDLE;
          end else if (mem_ack) begin
            line_o[128*beat +: 128] <= mem_dat;
            beat    <= beat + 1'b1;
            mem_adr <= mem_adr + AWID'(16);
            tmo     <= '0;
            if (beat == BW'(BEATS - 1)) begin
              mem_req <= 1'b0;
              tag_wr  <= 1'b1;
              line_wr <= 1'b1;
              tag_ipo <= {tag_r, 6'd0};
              state   <= WRITE;
            end
          end else begin
            tmo <= tmo + 1'b1;
          end
        end
        WRITE: begin
          vld[tag_way][set_r] <= 1'b1;
          victim <= victim + 2'd1;
          state  <= CHECK;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/rfphoenix_icache_refill.md
Name: rfphoenix_icache_refill

Overview:
- Consumer and producer for the icache tag RAM.
- Compares the four way tags returned for a fetch index and reports a hit or miss.
- On a miss, picks a victim way and fetches the 64-byte line as BEATS 128-bit bus reads.
- Presents the assembled line, then issues the tag-RAM write (wr/ipo/way) that installs it.
- Sits between the fetch stage, the ictag/icache data RAMs and the memory-bus port.

Parameters:
AWID, 32, address width
LINES, 128, sets per way (index = ip[12:6])
WAYS, 4, associativity (fixed at 4; victim/way fields are 2 bits)
BEATS, 4, 128-bit beats per 64-byte line
TMO, 255, bus cycles without ack before timeout error

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
req  in  1  fetch request valid (ip sampled when req & ~busy)
ip  in  AWID  fetch address
ndx  out  7  tag RAM read index = ip[12:6] (combinational)
tags_i  in  4*(AWID-6)  way tags from tag RAM, way0 in LSBs, valid one cycle after ndx
hit  out  1  one-cycle pulse: lookup hit
hit_way  out  2  way that hit, qualified by hit
busy  out  1  lookup/refill in progress; req ignored
mem_req  out  1  bus read request
mem_adr  out  AWID  bus beat address, 16-byte aligned
mem_ack  in  1  beat data valid
mem_dat  in  128  beat data
mem_err  in  1  bus error, ends refill
line_o  out  512  assembled line, beat n at bits [128n+127:128n]
line_wr  out  1  data RAM write strobe (same cycle as tag_wr)
tag_wr  out  1  tag RAM write strobe
tag_ipo  out  AWID  line address to tag RAM, low 6 bits zero
tag_way  out  2  way to write
err  out  1  one-cycle pulse: bus error or timeout

Behaviour:
- Reset values: all outputs 0; state IDLE; valid bits (WAYS*LINES) cleared; victim counter 0; beat counter 0; timeout counter 0.
- States: IDLE, CHECK, FETCH, WRITE.
- IDLE: on req, register ip_r <= ip, set busy, go to CHECK. ndx tracks ip every cycle so tags_i is valid in CHECK.
- CHECK: way w hits when valid[w][ip_r[12:6]] and tags_i[w] == ip_r[AWID-1:6].
  - Multiple hits: lowest way wins.
  - Hit: pulse hit with hit_way, clear busy, go to IDLE. Hit latency is 2 cycles from req.
  - Miss: tag_way <= victim, beat counter <= 0, mem_adr <= {ip_r[AWID-1:6], 6'd0}, go to FETCH.
- FETCH: mem_req held high.
  - Each mem_ack stores mem_dat into beat slot `beat`, increments beat, adds 16 to mem_adr, resets timeout.
  - Last beat (beat == BEATS-1 acked): drop mem_req, go to WRITE.
  - mem_err, or timeout counter reaching TMO: drop mem_req, pulse err, no tag or data write, valid untouched, clear busy, go to IDLE.
  - mem_err and mem_ack in the same cycle: error wins.
- WRITE, single cycle:
  - tag_wr = line_wr = 1, tag_ipo = {ip_r[AWID-1:6], 6'd0}.
  - Set valid[tag_way][ip_r[12:6]]; victim <= victim + 1 (wraps 3 -> 0).
  - Go to CHECK, re-presenting ndx = ip_r[12:6]. The tag RAM needs one cycle, so CHECK is entered the cycle after WRITE; that retry must hit on tag_way.
- ndx source: ip in IDLE, ip_r otherwise.
- req while busy is ignored; the fetch stage holds req/ip until hit.
- Reset mid-FETCH: mem_req drops the same cycle rst is sampled; no tag_wr; partial line discarded.
- line_o holds its value until the next refill's first beat.

Test Plan:
- After reset, req ip=0x0000_1040: CHECK misses (valid clear); mem_adr 0x1040, 0x1050, 0x1060, 0x1070 on successive acks; tag_wr with tag_ipo=0x1040, tag_way=0; hit pulse with hit_way=0 two cycles after WRITE.
- Repeat req 0x1044 after the fill: hit pulse with hit_way=0 two cycles after req; mem_req never asserts.
- Five misses to distinct tags in set 0x41: tag_way sequence 0,1,2,3,0; fifth fill evicts the first line; req to the first address then misses.
- mem_err on beat 2 of a refill: err pulse, no tag_wr/line_wr, busy clears; re-request refills from beat 0.
- No mem_ack for TMO=255 cycles: err pulse at cycle 255, mem_req low, state IDLE.
- rst asserted mid-FETCH after 2 acks: mem_req low next cycle, no tag_wr, next req to the same address misses.
